gol_board_arbiter: RTL
======================

GOL_BOARD_ARBITER -- requirements
Module: gol_board_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, board RAM address width (64x64 cells).
REQ-002 Parameter STARVE_LIM, default 8, consecutive denied cycles before a background requester overrides display.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 disp_req / disp_addr / disp_gnt / disp_rvalid / disp_rdata  in/in/out/out/out  1/ADDR_W/1/1/1  display read port.
REQ-006 upd_req / upd_we / upd_addr / upd_wdata / upd_gnt / upd_rvalid / upd_rdata  in/in/in/in/out/out/out  1/1/ADDR_W/1/1/1/1  update-engine read/write port.
REQ-007 ini_req / ini_we / ini_addr / ini_wdata / ini_gnt / ini_rvalid / ini_rdata  in/in/in/in/out/out/out  1/1/ADDR_W/1/1/1/1  init/copy-engine read/write port.
REQ-008 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/1  single-port board RAM command.
REQ-009 mem_rdata  in  1  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-010 disp_miss_cnt  out  16  count of display requests not granted.

Function
REQ-011 At most one of disp_gnt, upd_gnt, ini_gnt SHALL be high in any cycle; grants are combinational from current requests and registered state.
REQ-012 A gnt SHALL never be high without its req.
REQ-013 Default priority: display wins whenever disp_req=1, unless REQ-015 applies.
REQ-014 Without display grant, upd and ini arbitrate round-robin; pointer rr (1 bit) names the preferred requester, updates to the other requester after any cycle in which the preferred one is granted.
REQ-015 starve_upd / starve_ini counters (width clog2(STARVE_LIM)+1): increment each cycle own req=1 and own gnt=0; clear when granted or req=0; at count >= STARVE_LIM that requester wins over display; if both starved, rr decides.
REQ-016 mem_en = OR of grants; mem_addr/mem_we/mem_wdata SHALL mux from the granted port; display port always mem_we=0; idle mem_* outputs zero.
REQ-017 Read return: a registered owner tag SHALL route mem_rdata to the granting port's rdata with a one-cycle *_rvalid pulse exactly one cycle after a read grant; writes produce no rvalid.
REQ-018 *_rdata outputs SHALL all carry mem_rdata; only rvalid is gated per port.
REQ-019 Back-to-back grants to different ports each cycle SHALL return read data in grant order, one per cycle, no loss.
REQ-020 Requester holds req/addr/we/wdata stable until gnt; arbiter treats a dropped req as withdrawn, no error.
REQ-021 disp_miss_cnt increments by 1 each cycle disp_req=1 and disp_gnt=0; saturates at 16'hFFFF.
REQ-022 Write and read same address in consecutive cycles: read returns the newly written value (RAM-defined; arbiter adds no reordering).

Reset
REQ-023 rst_n=0 SHALL asynchronously clear: rr=0 (upd preferred), both starve counters, owner tag, all *_rvalid, disp_miss_cnt; grants and mem_en then follow combinationally from req inputs gated low during reset.
REQ-024 Reset mid-transaction SHALL drop any pending rvalid; no grant or mem_en while rst_n=0.
REQ-025 First grant possible in the first cycle after rst_n deasserts.

Verification
REQ-026 Only upd_req=1 read addr 0x041 -> upd_gnt same cycle, mem_addr=0x041, mem_we=0; next cycle upd_rvalid=1, upd_rdata=mem_rdata.
REQ-027 upd_req and ini_req held high 4 cycles after reset -> grants upd,ini,upd,ini; rr alternates.
REQ-028 disp_req high continuously, upd_req high (STARVE_LIM=8) -> disp_gnt cycles 0-7, upd_gnt cycle 8, disp_gnt resumes cycle 9; disp_miss_cnt=1.
REQ-029 Grant sequence disp-read, upd-write, ini-read on consecutive cycles -> disp_rvalid at +1, no upd_rvalid, ini_rvalid at +3; never two rvalids together.
REQ-030 disp_req=1 with forced denial 70000 cycles -> disp_miss_cnt saturates at 0xFFFF.
REQ-031 rst_n low one cycle after a read grant -> no rvalid ever; all counters 0; rr=0.

Source files
------------

// File: rtl/gol_board_arbiter.sv
// Board RAM arbiter: shares one single-port RAM between the display scanout,
// the life update engine and the init/copy engine. Display has priority,
// with starvation override for the two background engines.
module gol_board_arbiter #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // display read port
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic              disp_rdata,
   // update-engine port
   input  logic              upd_req,
   input  logic              upd_we,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic              upd_wdata,
   output logic              upd_gnt,
   output logic              upd_rvalid,
   output logic              upd_rdata,
   // init/copy-engine port
   input  logic              ini_req,
   input  logic              ini_we,
   input  logic [ADDR_W-1:0] ini_addr,
   input  logic              ini_wdata,
   output logic              ini_gnt,
   output logic              ini_rvalid,
   output logic              ini_rdata,
   // board RAM
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wdata,
   input  logic              mem_rdata,
   // statistics
   output logic [15:0]       disp_miss_cnt
);

   localparam int unsigned CNT_W  = $clog2(STARVE_LIM) + 1;
   localparam int unsigned MISS_W = 16;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DISP = 2'd1;
   localparam logic [1:0] OWN_UPD  = 2'd2;
   localparam logic [1:0] OWN_INI  = 2'd3;

   logic              rr_q, rr_d;
   logic [CNT_W-1:0]  starve_upd_q, starve_upd_d;
   logic [CNT_W-1:0]  starve_ini_q, starve_ini_d;
   logic [1:0]        owner_q, owner_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   logic d_req, u_req, i_req;
   logic u_starved, i_starved;
   logic g_d, g_u, g_i;

   // Requests are masked while reset is asserted so nothing is granted.
   assign d_req = disp_req & rst_n;
   assign u_req = upd_req  & rst_n;
   assign i_req = ini_req  & rst_n;

   assign u_starved = u_req & (starve_upd_q >= CNT_W'(STARVE_LIM));
   assign i_starved = i_req & (starve_ini_q >= CNT_W'(STARVE_LIM));

   // Grant selection: starved engines, then display, then round-robin.
   always_comb begin
      g_d = 1'b0;
      g_u = 1'b0;
      g_i = 1'b0;
      if (u_starved && i_starved) begin
         if (!rr_q) g_u = 1'b1;
         else       g_i = 1'b1;
      end else if (u_starved) begin
         g_u = 1'b1;
      end else if (i_starved) begin
         g_i = 1'b1;
      end else if (d_req) begin
         g_d = 1'b1;
      end else if (u_req && i_req) begin
         if (!rr_q) g_u = 1'b1;
         else       g_i = 1'b1;
      end else if (u_req) begin
         g_u = 1'b1;
      end else if (i_req) begin
         g_i = 1'b1;
      end
   end

   assign disp_gnt = g_d;
   assign upd_gnt  = g_u;
   assign ini_gnt  = g_i;

   // RAM command mux from the granted port; all zero when idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 1'b0;
      if (g_d) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (g_u) begin
         mem_en    = 1'b1;
         mem_we    = upd_we;
         mem_addr  = upd_addr;
         mem_wdata = upd_wdata;
      end else if (g_i) begin
         mem_en    = 1'b1;
         mem_we    = ini_we;
         mem_addr  = ini_addr;
         mem_wdata = ini_wdata;
      end
   end

   // Next-state: rr pointer, starvation counters, read owner tag, miss count.
   always_comb begin
      rr_d         = rr_q;
      starve_upd_d = '0;
      starve_ini_d = '0;
      owner_d      = OWN_NONE;
      miss_d       = miss_q;

      if ((!rr_q && g_u) || (rr_q && g_i)) rr_d = ~rr_q;

      if (u_req && !g_u) begin
         if (starve_upd_q < CNT_W'(STARVE_LIM)) starve_upd_d = starve_upd_q + CNT_W'(1);
         else                                   starve_upd_d = starve_upd_q;
      end
      if (i_req && !g_i) begin
         if (starve_ini_q < CNT_W'(STARVE_LIM)) starve_ini_d = starve_ini_q + CNT_W'(1);
         else                                   starve_ini_d = starve_ini_q;
      end

      if (g_d)                  owner_d = OWN_DISP;
      else if (g_u && !upd_we)  owner_d = OWN_UPD;
      else if (g_i && !ini_we)  owner_d = OWN_INI;

      if (d_req && !g_d && (miss_q != {MISS_W{1'b1}})) miss_d = miss_q + MISS_W'(1);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q         <= 1'b0;
         starve_upd_q <= '0;
         starve_ini_q <= '0;
         owner_q      <= OWN_NONE;
         miss_q       <= '0;
      end else begin
         rr_q         <= rr_d;
         starve_upd_q <= starve_upd_d;
         starve_ini_q <= starve_ini_d;
         owner_q      <= owner_d;
         miss_q       <= miss_d;
      end
   end

   // Read return: RAM data is shared, only the valid strobe follows the owner tag.
   assign disp_rvalid   = (owner_q == OWN_DISP);
   assign upd_rvalid    = (owner_q == OWN_UPD);
   assign ini_rvalid    = (owner_q == OWN_INI);
   assign disp_rdata    = mem_rdata;
   assign upd_rdata     = mem_rdata;
   assign ini_rdata     = mem_rdata;
   assign disp_miss_cnt = miss_q;

endmodule
